iir_sequencer: RTL and testbench

- Controller for a first-order Q16.16 IIR section: y[n] = b0·x[n] + b1·x[n-1] + a·y[n-1] + offset.
- Time-multiplexes a single pipelined signed multiplier across the three products per sample and accumulates them onto the offset.
- Sits between the sample source and the consumer with valid/ready handshakes on both sides.
- Holds shadow coefficient registers so software or a bench can reconfigure the filter without corrupting a sample in flight.

---
 rtl/iir_pkg.sv | 23 ++
 rtl/iir_mul_q.sv | 47 ++++
 rtl/iir_sequencer.sv | 152 +++++++++++++++
 tb/tb_iir_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/iir_pkg.sv
// Shared types for the Q16.16 first-order IIR sequencer: widths, FSM states, coefficient set.
// Widths here are the defaults the sequencer and multiplier are built around.
package iir_pkg;
   localparam int DEF_N_BITS    = 32;
   localparam int DEF_FRAC_BITS = 16;

   typedef logic signed [DEF_N_BITS-1:0]   sample_t;
   typedef logic signed [2*DEF_N_BITS-1:0] prod_t;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUT} state_t;

   typedef struct packed {
      sample_t b0;
      sample_t b1;
      sample_t a;
      sample_t offset;
   } coef_t;

   // Signed overflow of sum = lhs + rhs: like-signed operands producing an opposite-signed result.
   function automatic logic add_ovf(input sample_t lhs, input sample_t rhs, input sample_t sum);
      return (lhs[DEF_N_BITS-1] == rhs[DEF_N_BITS-1]) && (sum[DEF_N_BITS-1] != lhs[DEF_N_BITS-1]);
   endfunction
endpackage

// File: rtl/iir_mul_q.sv
// Pipelined signed Q-format multiplier: MUL_LAT register stages, result truncated (floor) to N_BITS.
// No backpressure; flush kills every product in flight so it never reaches the accumulator.
module iir_mul_q
   import iir_pkg::*;
#(
   parameter int N_BITS    = DEF_N_BITS,
   parameter int FRAC_BITS = DEF_FRAC_BITS,
   parameter int MUL_LAT   = 1
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_vld,
   input  logic [N_BITS-1:0] op_a,
   input  logic [N_BITS-1:0] op_b,
   output logic              out_vld,
   output logic [N_BITS-1:0] res,
   output logic              ovf
);
   prod_t                    a_ext, b_ext;
   prod_t                    prod_q [MUL_LAT];
   logic [MUL_LAT-1:0]       vld_q;
   logic [N_BITS-FRAC_BITS:0] head;

   assign a_ext = {{N_BITS{op_a[N_BITS-1]}}, op_a};
   assign b_ext = {{N_BITS{op_b[N_BITS-1]}}, op_b};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < MUL_LAT; i++) prod_q[i] <= '0;
         vld_q <= '0;
      end else begin
         prod_q[0] <= a_ext * b_ext;
         vld_q[0]  <= in_vld && !flush;
         for (int i = 1; i < MUL_LAT; i++) begin
            prod_q[i] <= prod_q[i-1];
            vld_q[i]  <= vld_q[i-1] && !flush;
         end
      end
   end

   // The kept field plus everything above it must be pure sign extension, else the Q result wrapped.
   assign head    = prod_q[MUL_LAT-1][2*N_BITS-1:FRAC_BITS+N_BITS-1];
   assign out_vld = vld_q[MUL_LAT-1];
   assign res     = N_BITS'(prod_q[MUL_LAT-1] >>> FRAC_BITS);
   assign ovf     = out_vld && !((&head) || !(|head));
endmodule

// File: rtl/iir_sequencer.sv
// First-order IIR y = b0*x + b1*x1 + a*y1 + offset on one shared multiplier; y_valid_o 4+MUL_LAT edges after accept.
// One sample in flight: x_ready_o stays low until the result is taken on y_ready_i.
module iir_sequencer
   import iir_pkg::*;
#(
   parameter int N_BITS    = DEF_N_BITS,
   parameter int FRAC_BITS = DEF_FRAC_BITS,
   parameter int MUL_LAT   = 1
)(
   input  logic              clk,
   input  logic              reset,
   input  logic [N_BITS-1:0] x_i,
   input  logic              x_valid_i,
   output logic              x_ready_o,
   input  logic [N_BITS-1:0] b0_i,
   input  logic [N_BITS-1:0] b1_i,
   input  logic [N_BITS-1:0] a_i,
   input  logic [N_BITS-1:0] offset_i,
   input  logic              coef_load_i,
   input  logic              clear_i,
   output logic [N_BITS-1:0] y_o,
   output logic              y_valid_o,
   input  logic              y_ready_i,
   output logic              busy_o,
   output logic              ovf_o
);
   localparam int            DW         = $clog2(MUL_LAT + 2);
   localparam logic [DW-1:0] DRAIN_LAST = DW'(MUL_LAT);

   state_t        state, state_nxt;
   coef_t         shadow, staging, snap;
   sample_t       w_b0, w_b1, w_a;
   sample_t       x_q, x1, y1, acc, acc_sum, y_q;
   sample_t       mul_a, mul_b, mul_res;
   logic [1:0]    op_cnt;
   logic [DW-1:0] drain_cnt;
   logic          rdy_en, ovf_q, accept, mul_in_vld, mul_vld, mul_ovf;

   assign staging = {b0_i, b1_i, a_i, offset_i};
   // A load on the accepting edge wins over the older shadow contents.
   assign snap    = coef_load_i ? staging : shadow;
   assign accept  = x_valid_i && x_ready_o && !clear_i;
   assign acc_sum = acc + mul_res;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (clear_i) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (accept) state_nxt = ISSUE;
            ISSUE:   if (op_cnt == 2'd2) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt == DRAIN_LAST) state_nxt = OUT;
            OUT:     if (y_ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      x_ready_o  = (state == IDLE) && rdy_en;
      y_valid_o  = (state == OUT);
      busy_o     = (state != IDLE);
      mul_in_vld = (state == ISSUE);
   end

   // DRAIN spans MUL_LAT cycles for the last product plus one for its accumulate.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdy_en    <= 1'b0;
         shadow    <= '0;
         w_b0      <= '0;
         w_b1      <= '0;
         w_a       <= '0;
         x_q       <= '0;
         x1        <= '0;
         y1        <= '0;
         acc       <= '0;
         y_q       <= '0;
         ovf_q     <= 1'b0;
         op_cnt    <= '0;
         drain_cnt <= '0;
      end else begin
         rdy_en <= 1'b1;
         if (coef_load_i) shadow <= staging;
         if (clear_i) begin
            x1        <= '0;
            y1        <= '0;
            acc       <= '0;
            ovf_q     <= 1'b0;
            op_cnt    <= '0;
            drain_cnt <= '0;
         end else begin
            if (mul_ovf || (mul_vld && add_ovf(acc, mul_res, acc_sum))) ovf_q <= 1'b1;
            if (accept) begin
               x_q       <= x_i;
               w_b0      <= snap.b0;
               w_b1      <= snap.b1;
               w_a       <= snap.a;
               acc       <= snap.offset;
               op_cnt    <= '0;
               drain_cnt <= '0;
            end else if (mul_vld) begin
               acc <= acc_sum;
            end
            if (state == ISSUE) op_cnt <= op_cnt + 2'd1;
            if (state == DRAIN) begin
               drain_cnt <= drain_cnt + DW'(1);
               if (drain_cnt == DRAIN_LAST) begin
                  y_q <= acc;
                  x1  <= x_q;
                  y1  <= acc;
               end
            end
         end
      end
   end

   always_comb begin
      mul_a = '0;
      mul_b = '0;
      case (op_cnt)
         2'd0:    begin mul_a = w_b0; mul_b = x_q; end
         2'd1:    begin mul_a = w_b1; mul_b = x1;  end
         default: begin mul_a = w_a;  mul_b = y1;  end
      endcase
   end

   iir_mul_q #(
      .N_BITS    (N_BITS),
      .FRAC_BITS (FRAC_BITS),
      .MUL_LAT   (MUL_LAT)
   ) u_mul (
      .clk     (clk),
      .reset   (reset),
      .flush   (clear_i),
      .in_vld  (mul_in_vld),
      .op_a    (mul_a),
      .op_b    (mul_b),
      .out_vld (mul_vld),
      .res     (mul_res),
      .ovf     (mul_ovf)
   );

   assign y_o   = y_q;
   assign ovf_o = ovf_q;
endmodule

// File: tb/tb_iir_sequencer.sv
// Scoreboard bench for iir_sequencer: directed scenarios then randomized samples against an arithmetic model.
module tb_iir_sequencer;
   localparam int ML  = 1;
   localparam int LAT = 4 + ML;

   logic        clk = 1'b0, reset = 1'b0;
   logic [31:0] x_i = '0, b0_i = '0, b1_i = '0, a_i = '0, offset_i = '0;
   logic        x_valid_i = 1'b0, coef_load_i = 1'b0, clear_i = 1'b0, y_ready_i = 1'b1;
   logic        x_ready_o, y_valid_o, busy_o, ovf_o;
   logic [31:0] y_o;

   iir_sequencer #(.N_BITS(32), .FRAC_BITS(16), .MUL_LAT(ML)) dut (
      .clk(clk), .reset(reset), .x_i(x_i), .x_valid_i(x_valid_i), .x_ready_o(x_ready_o),
      .b0_i(b0_i), .b1_i(b1_i), .a_i(a_i), .offset_i(offset_i), .coef_load_i(coef_load_i),
      .clear_i(clear_i), .y_o(y_o), .y_valid_o(y_valid_o), .y_ready_i(y_ready_i),
      .busy_o(busy_o), .ovf_o(ovf_o)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] y; logic ovf; int acc_cyc; } exp_t;
   exp_t sb[$];
   int total = 0, bad = 0, cyc = 0, pops = 0;
   logic [31:0] m_b0 = '0, m_b1 = '0, m_a = '0, m_off = '0, m_x1 = '0, m_y1 = '0;
   logic        m_ovf = 1'b0;
   bit          rdy_rand = 1'b0;
   logic        rdy_level = 1'b1;
   logic        prev_vld = 1'b0;

   always @(posedge clk) cyc++;
   always @(posedge clk) begin
      #1;
      y_ready_i = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_level;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      total++;
      bad++;
      $display("FAIL %s: no progress within bound (t=%0t)", name, $time);
   endtask

   // y = offset + b0*x + b1*x1 + a*y1, each product floored to Q16.16, 32-bit wrapping sum.
   function automatic void model_sample(input logic [31:0] x, input int acc_cyc);
      logic [31:0] c [3];
      logic [31:0] v [3];
      longint p, s, top;
      int     acc, r;
      c = '{m_b0, m_b1, m_a};
      v = '{x, m_x1, m_y1};
      acc = int'(m_off);
      for (int k = 0; k < 3; k++) begin
         p   = longint'(int'(c[k])) * longint'(int'(v[k]));
         top = p >>> 47;
         if (top != 0 && top != -1) m_ovf = 1'b1;
         r = int'(p >>> 16);
         s = longint'(acc) + longint'(r);
         if (s != longint'(int'(s))) m_ovf = 1'b1;
         acc = int'(s);
      end
      m_x1 = x;
      m_y1 = acc;
      sb.push_back('{acc, m_ovf, acc_cyc});
   endfunction

   function automatic void model_reset(input bit coefs_too);
      m_x1 = '0; m_y1 = '0; m_ovf = 1'b0;
      if (coefs_too) begin m_b0 = '0; m_b1 = '0; m_a = '0; m_off = '0; end
      sb.delete();
   endfunction

   always @(negedge clk) begin
      if (reset && y_valid_o) begin
         if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_output: got y=%0h with nothing outstanding", y_o);
         end else begin
            if (!prev_vld) chk("latency", 64'(cyc - sb[0].acc_cyc), 64'(LAT));
            chk("y", 64'(y_o), 64'(sb[0].y));
            chk("ovf_at_out", 64'(ovf_o), 64'(sb[0].ovf));
            chk("x_ready_in_out", 64'(x_ready_o), 64'd0);
            if (y_ready_i) begin
               void'(sb.pop_front());
               pops++;
            end
         end
      end
      prev_vld = reset && y_valid_o;
   end

   task automatic load(input logic [31:0] b0, input logic [31:0] b1, input logic [31:0] a, input logic [31:0] off);
      b0_i = b0; b1_i = b1; a_i = a; offset_i = off;
      coef_load_i = 1'b1;
      m_b0 = b0; m_b1 = b1; m_a = a; m_off = off;
      @(negedge clk);
      coef_load_i = 1'b0;
   endtask

   task automatic send(input logic [31:0] x, input bit ld);
      int n = 0;
      x_i = x;
      x_valid_i = 1'b1;
      while (!x_ready_o && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) timeout("x_ready_wait");
      else begin
         if (ld) begin
            coef_load_i = 1'b1;
            m_b0 = b0_i; m_b1 = b1_i; m_a = a_i; m_off = offset_i;
         end
         model_sample(x, cyc + 1);
      end
      @(negedge clk);
      x_valid_i = 1'b0;
      coef_load_i = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((sb.size() != 0 || busy_o) && n < 300) begin @(negedge clk); n++; end
      if (n >= 300) timeout("drain_wait");
   endtask

   task automatic do_clear();
      clear_i = 1'b1;
      model_reset(1'b0);
      @(negedge clk);
      clear_i = 1'b0;
      chk("clear_busy", 64'(busy_o), 64'd0);
      chk("clear_y_valid", 64'(y_valid_o), 64'd0);
      chk("clear_ovf", 64'(ovf_o), 64'd0);
   endtask

   function automatic logic [31:0] rnd(input int unsigned span);
      logic [31:0] r;
      r = 32'($urandom_range(0, 2 * span));
      return r - span;
   endfunction

   initial begin
      int n, p0;
      repeat (3) @(negedge clk);
      chk("rst_x_ready", 64'(x_ready_o), 64'd0);
      chk("rst_y_valid", 64'(y_valid_o), 64'd0);
      chk("rst_busy", 64'(busy_o), 64'd0);
      chk("rst_ovf", 64'(ovf_o), 64'd0);
      chk("rst_y", 64'(y_o), 64'd0);
      reset = 1'b1;
      #1 chk("x_ready_before_edge", 64'(x_ready_o), 64'd0);
      @(negedge clk);
      chk("x_ready_after_edge", 64'(x_ready_o), 64'd1);

      // Impulse response.
      load(32'h0000_12AD, 32'h0000_12AD, 32'hFFFF_255C, 32'h0);
      send(32'h0001_0000, 1'b0);
      send(32'h0, 1'b0);
      wait_idle();

      // Back-pressure: hold the result for 10 cycles, then exactly one pop.
      rdy_level = 1'b0;
      send(32'h0000_8000, 1'b0);
      n = 0;
      while (!y_valid_o && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) timeout("bp_valid_wait");
      repeat (10) @(negedge clk);
      p0 = pops;
      rdy_level = 1'b1;
      repeat (4) @(negedge clk);
      chk("bp_single_pop", 64'(pops - p0), 64'd1);
      wait_idle();

      // Coefficient load while a sample is in ISSUE.
      send(32'h0001_0000, 1'b0);
      load(32'h0001_0000, 32'h0000_12AD, 32'hFFFF_255C, 32'h0);
      wait_idle();
      send(32'h0003_0000, 1'b0);
      wait_idle();

      // Overflow: 32767.0 * 2.0.
      do_clear();
      load(32'h7FFF_0000, 32'h0, 32'h0, 32'h0);
      send(32'h0002_0000, 1'b0);
      wait_idle();
      repeat (5) @(negedge clk);
      chk("ovf_sticky", 64'(ovf_o), 64'd1);
      do_clear();

      // Clear during DRAIN, then the impulse must repeat exactly.
      load(32'h0000_12AD, 32'h0000_12AD, 32'hFFFF_255C, 32'h0);
      send(32'h0001_0000, 1'b0);
      repeat (3) @(negedge clk);
      chk("busy_in_drain", 64'(busy_o), 64'd1);
      do_clear();
      repeat (6) @(negedge clk);
      send(32'h0001_0000, 1'b0);
      send(32'h0, 1'b0);
      wait_idle();

      // Reset low mid-ISSUE.
      send(32'h0001_0000, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      model_reset(1'b1);
      #1;
      chk("arst_x_ready", 64'(x_ready_o), 64'd0);
      chk("arst_y_valid", 64'(y_valid_o), 64'd0);
      chk("arst_busy", 64'(busy_o), 64'd0);
      chk("arst_y", 64'(y_o), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      load(32'h0000_12AD, 32'h0000_12AD, 32'hFFFF_255C, 32'h0);
      send(32'h0001_0000, 1'b0);
      send(32'h0, 1'b0);
      wait_idle();

      // Load coincident with the accepting edge.
      b0_i = 32'h0002_0000; b1_i = 32'h0000_8000; a_i = 32'h0000_4000; offset_i = 32'h0000_1000;
      send(32'h0001_8000, 1'b1);
      wait_idle();

      // Randomized stream with random back-pressure and in-flight coefficient loads.
      rdy_rand = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) == 0)
            load(rnd(32'h4_0000), rnd(32'h4_0000), rnd(32'h1_0000), rnd(32'h10_0000));
         b0_i = rnd(32'h2_0000); b1_i = rnd(32'h2_0000); a_i = rnd(32'h1_0000); offset_i = rnd(32'h1_0000);
         send(rnd(32'h8_0000), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 2) == 0)
            load(rnd(32'h7FFF_0000), rnd(32'h2_0000), rnd(32'h1_0000), rnd(32'h10_0000));
      end
      wait_idle();
      rdy_rand = 1'b0;
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
